// File: rtl/icb_mxs_bridge.sv
// ICB multi-master / multi-slave bridge with fixed or round-robin arbitration, an in-order
// outstanding-transaction FIFO for response routing, and an internal error slave for unmapped targets.
module icb_mxs_bridge #(
    parameter int NUM_MST   = 2,
    parameter int NUM_SLV   = 8,
    parameter int SEL_W     = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ARB_MODE  = 0,
    parameter int OST_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MST-1:0]            m_icb_cmd_valid,
    output logic [NUM_MST-1:0]            m_icb_cmd_ready,
    input  logic [NUM_MST*ADDR_W-1:0]     m_icb_cmd_addr,
    input  logic [NUM_MST-1:0]            m_icb_cmd_read,
    input  logic [NUM_MST*DATA_W-1:0]     m_icb_cmd_wdata,
    input  logic [NUM_MST*DATA_W/8-1:0]   m_icb_cmd_wmask,
    output logic [NUM_MST-1:0]            m_icb_rsp_valid,
    input  logic [NUM_MST-1:0]            m_icb_rsp_ready,
    output logic [NUM_MST-1:0]            m_icb_rsp_err,
    output logic [NUM_MST*DATA_W-1:0]     m_icb_rsp_rdata,
    output logic [NUM_SLV-1:0]            s_icb_cmd_valid,
    input  logic [NUM_SLV-1:0]            s_icb_cmd_ready,
    output logic [NUM_SLV*ADDR_W-1:0]     s_icb_cmd_addr,
    output logic [NUM_SLV-1:0]            s_icb_cmd_read,
    output logic [NUM_SLV*DATA_W-1:0]     s_icb_cmd_wdata,
    output logic [NUM_SLV*DATA_W/8-1:0]   s_icb_cmd_wmask,
    input  logic [NUM_SLV-1:0]            s_icb_rsp_valid,
    output logic [NUM_SLV-1:0]            s_icb_rsp_ready,
    input  logic [NUM_SLV-1:0]            s_icb_rsp_err,
    input  logic [NUM_SLV*DATA_W-1:0]     s_icb_rsp_rdata
);

    localparam int MW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int PW = $clog2(OST_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = DATA_W / 8;
    localparam logic [SEL_W:0] NSLV_C  = (SEL_W+1)'(NUM_SLV);
    localparam logic [CW-1:0]  DEPTH_C = CW'(OST_DEPTH);
    localparam logic [MW-1:0]  LAST_M  = MW'(NUM_MST - 1);

    logic [CW-1:0]     cnt_r;
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [MW-1:0]     rr_ptr_r;
    logic              lock_r;
    logic [MW-1:0]     lock_gnt_r;
    logic [SEL_W-1:0]  last_tgt_r;
    logic [MW-1:0]     fifo_mst_r [OST_DEPTH];
    logic [SEL_W-1:0]  fifo_tgt_r [OST_DEPTH];

    logic [MW-1:0]     arb_gnt_s;
    logic [MW-1:0]     grant_s;
    logic [MW-1:0]     rr_next_s;
    logic              gvalid_s;
    logic [ADDR_W-1:0] gaddr_s;
    logic              gread_s;
    logic [DATA_W-1:0] gwdata_s;
    logic [BW-1:0]     gwmask_s;
    logic [SEL_W-1:0]  tgt_sel_s;
    logic              tgt_err_s;
    logic              sready_s;
    logic              accept_s;
    logic              hs_s;

    logic [MW-1:0]     head_mst_s;
    logic [SEL_W-1:0]  head_tgt_s;
    logic              head_err_s;
    logic              rsp_active_s;
    logic              srv_s;
    logic              sre_s;
    logic [DATA_W-1:0] srd_s;
    logic              mrr_s;
    logic              pop_s;

    // Arbitration: lowest valid index, or first valid index at/after rr_ptr (smallest distance wins)
    always_comb begin
        arb_gnt_s = {MW{1'b0}};
        if (ARB_MODE == 1) begin
            for (int k = NUM_MST - 1; k >= 0; k--) begin
                for (int i = 0; i < NUM_MST; i++) begin
                    arb_gnt_s = (m_icb_cmd_valid[i] && (i == (int'(rr_ptr_r) + k) % NUM_MST))
                                ? i[MW-1:0] : arb_gnt_s;
                end
            end
        end else begin
            for (int i = NUM_MST - 1; i >= 0; i--) begin
                arb_gnt_s = m_icb_cmd_valid[i] ? i[MW-1:0] : arb_gnt_s;
            end
        end
    end

    assign grant_s   = lock_r ? lock_gnt_r : arb_gnt_s;
    assign rr_next_s = (grant_s == LAST_M) ? {MW{1'b0}} : grant_s + MW'(1);

    // Granted-master command fields
    always_comb begin
        gvalid_s = 1'b0;
        gaddr_s  = {ADDR_W{1'b0}};
        gread_s  = 1'b0;
        gwdata_s = {DATA_W{1'b0}};
        gwmask_s = {BW{1'b0}};
        for (int i = 0; i < NUM_MST; i++) begin
            if (grant_s == i[MW-1:0]) begin
                gvalid_s = m_icb_cmd_valid[i];
                gaddr_s  = m_icb_cmd_addr[i*ADDR_W +: ADDR_W];
                gread_s  = m_icb_cmd_read[i];
                gwdata_s = m_icb_cmd_wdata[i*DATA_W +: DATA_W];
                gwmask_s = m_icb_cmd_wmask[i*BW +: BW];
            end else begin
                gvalid_s = gvalid_s;
            end
        end
    end

    assign tgt_sel_s = gaddr_s[ADDR_W-1 -: SEL_W];
    assign tgt_err_s = ({1'b0, tgt_sel_s} >= NSLV_C);

    // Ready of the targeted slave
    always_comb begin
        sready_s = 1'b0;
        for (int s = 0; s < NUM_SLV; s++) begin
            sready_s = (tgt_sel_s == s[SEL_W-1:0]) ? s_icb_cmd_ready[s] : sready_s;
        end
    end

    // Only one target may be outstanding at a time, which keeps responses in issue order
    assign accept_s = !rst && (cnt_r < DEPTH_C) &&
                      ((cnt_r == {CW{1'b0}}) || (tgt_sel_s == last_tgt_r));
    assign hs_s     = gvalid_s && accept_s && (tgt_err_s || sready_s);

    // Command valid/ready steering
    always_comb begin
        m_icb_cmd_ready = {NUM_MST{1'b0}};
        s_icb_cmd_valid = {NUM_SLV{1'b0}};
        if (accept_s && gvalid_s) begin
            for (int i = 0; i < NUM_MST; i++) begin
                m_icb_cmd_ready[i] = (grant_s == i[MW-1:0]) && (tgt_err_s || sready_s);
            end
            for (int s = 0; s < NUM_SLV; s++) begin
                s_icb_cmd_valid[s] = !tgt_err_s && (tgt_sel_s == s[SEL_W-1:0]);
            end
        end else begin
            m_icb_cmd_ready = {NUM_MST{1'b0}};
            s_icb_cmd_valid = {NUM_SLV{1'b0}};
        end
    end

    assign s_icb_cmd_addr  = {NUM_SLV{gaddr_s}};
    assign s_icb_cmd_read  = {NUM_SLV{gread_s}};
    assign s_icb_cmd_wdata = {NUM_SLV{gwdata_s}};
    assign s_icb_cmd_wmask = {NUM_SLV{gwmask_s}};

    assign head_mst_s   = fifo_mst_r[rd_ptr_r];
    assign head_tgt_s   = fifo_tgt_r[rd_ptr_r];
    assign head_err_s   = ({1'b0, head_tgt_s} >= NSLV_C);
    assign rsp_active_s = !rst && (cnt_r != {CW{1'b0}});

    // Head slave response fields and head master ready
    always_comb begin
        srv_s = 1'b0;
        sre_s = 1'b0;
        srd_s = {DATA_W{1'b0}};
        mrr_s = 1'b0;
        for (int s = 0; s < NUM_SLV; s++) begin
            if (head_tgt_s == s[SEL_W-1:0]) begin
                srv_s = s_icb_rsp_valid[s];
                sre_s = s_icb_rsp_err[s];
                srd_s = s_icb_rsp_rdata[s*DATA_W +: DATA_W];
            end else begin
                srv_s = srv_s;
            end
        end
        for (int i = 0; i < NUM_MST; i++) begin
            mrr_s = (head_mst_s == i[MW-1:0]) ? m_icb_rsp_ready[i] : mrr_s;
        end
    end

    // Response routing from the FIFO head; the error slave answers immediately with err=1, rdata=0
    always_comb begin
        m_icb_rsp_valid = {NUM_MST{1'b0}};
        m_icb_rsp_err   = {NUM_MST{1'b0}};
        m_icb_rsp_rdata = {(NUM_MST*DATA_W){1'b0}};
        s_icb_rsp_ready = {NUM_SLV{1'b0}};
        if (rsp_active_s) begin
            for (int i = 0; i < NUM_MST; i++) begin
                m_icb_rsp_valid[i] = (head_mst_s == i[MW-1:0]) && (head_err_s || srv_s);
                m_icb_rsp_err[i]   = (head_mst_s == i[MW-1:0]) && (head_err_s || sre_s);
                m_icb_rsp_rdata[i*DATA_W +: DATA_W] =
                    ((head_mst_s == i[MW-1:0]) && !head_err_s) ? srd_s : {DATA_W{1'b0}};
            end
            for (int s = 0; s < NUM_SLV; s++) begin
                s_icb_rsp_ready[s] = !head_err_s && (head_tgt_s == s[SEL_W-1:0]) && mrr_s;
            end
        end else begin
            m_icb_rsp_valid = {NUM_MST{1'b0}};
            s_icb_rsp_ready = {NUM_SLV{1'b0}};
        end
    end

    assign pop_s = rsp_active_s && (head_err_s || srv_s) && mrr_s;

    // Pointers, occupancy, arbitration and lock state
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {CW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            rd_ptr_r   <= {PW{1'b0}};
            rr_ptr_r   <= {MW{1'b0}};
            lock_r     <= 1'b0;
            lock_gnt_r <= {MW{1'b0}};
            last_tgt_r <= {SEL_W{1'b0}};
        end else begin
            if (hs_s) begin
                wr_ptr_r   <= wr_ptr_r + PW'(1);
                last_tgt_r <= tgt_sel_s;
                rr_ptr_r   <= rr_next_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({hs_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
            lock_r     <= gvalid_s && !hs_s;
            lock_gnt_r <= grant_s;
        end
    end

    // Outstanding-transaction storage (contents are don't-care while empty)
    always_ff @(posedge clk) begin
        if (!rst && hs_s) begin
            fifo_mst_r[wr_ptr_r] <= grant_s;
            fifo_tgt_r[wr_ptr_r] <= tgt_sel_s;
        end
    end

endmodule

// File: tb/tb_icb_mxs_bridge.sv
// Directed bench: fixed-priority bridge with 6 slaves (slaves 6/7 unmapped) and a round-robin bridge with 8 slaves.
module tb_icb_mxs_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Fixed-priority instance, NUM_SLV = 6
    logic         rst_f;
    logic [1:0]   f_mv, f_mr, f_mread, f_mrv, f_mrr, f_mre;
    logic [63:0]  f_maddr, f_mwdata, f_mrd;
    logic [7:0]   f_mwmask;
    logic [5:0]   f_sv, f_sr, f_sread, f_srv, f_srr, f_sre;
    logic [191:0] f_saddr, f_swdata, f_srd;
    logic [23:0]  f_swmask;

    // Round-robin instance, NUM_SLV = 8
    logic         rst_r;
    logic [1:0]   r_mv, r_mr, r_mread, r_mrv, r_mrr, r_mre;
    logic [63:0]  r_maddr, r_mwdata, r_mrd;
    logic [7:0]   r_mwmask;
    logic [7:0]   r_sv, r_sr, r_sread, r_srv, r_srr, r_sre;
    logic [255:0] r_saddr, r_swdata, r_srd;
    logic [31:0]  r_swmask;

    logic [1:0]   exp_g;

    icb_mxs_bridge #(.NUM_MST(2), .NUM_SLV(6), .SEL_W(3), .ADDR_W(32), .DATA_W(32),
                     .ARB_MODE(0), .OST_DEPTH(4)) u_fix (
        .clk(clk), .rst(rst_f),
        .m_icb_cmd_valid(f_mv), .m_icb_cmd_ready(f_mr), .m_icb_cmd_addr(f_maddr),
        .m_icb_cmd_read(f_mread), .m_icb_cmd_wdata(f_mwdata), .m_icb_cmd_wmask(f_mwmask),
        .m_icb_rsp_valid(f_mrv), .m_icb_rsp_ready(f_mrr), .m_icb_rsp_err(f_mre),
        .m_icb_rsp_rdata(f_mrd),
        .s_icb_cmd_valid(f_sv), .s_icb_cmd_ready(f_sr), .s_icb_cmd_addr(f_saddr),
        .s_icb_cmd_read(f_sread), .s_icb_cmd_wdata(f_swdata), .s_icb_cmd_wmask(f_swmask),
        .s_icb_rsp_valid(f_srv), .s_icb_rsp_ready(f_srr), .s_icb_rsp_err(f_sre),
        .s_icb_rsp_rdata(f_srd)
    );

    icb_mxs_bridge #(.NUM_MST(2), .NUM_SLV(8), .SEL_W(3), .ADDR_W(32), .DATA_W(32),
                     .ARB_MODE(1), .OST_DEPTH(4)) u_rr (
        .clk(clk), .rst(rst_r),
        .m_icb_cmd_valid(r_mv), .m_icb_cmd_ready(r_mr), .m_icb_cmd_addr(r_maddr),
        .m_icb_cmd_read(r_mread), .m_icb_cmd_wdata(r_mwdata), .m_icb_cmd_wmask(r_mwmask),
        .m_icb_rsp_valid(r_mrv), .m_icb_rsp_ready(r_mrr), .m_icb_rsp_err(r_mre),
        .m_icb_rsp_rdata(r_mrd),
        .s_icb_cmd_valid(r_sv), .s_icb_cmd_ready(r_sr), .s_icb_cmd_addr(r_saddr),
        .s_icb_cmd_read(r_sread), .s_icb_cmd_wdata(r_swdata), .s_icb_cmd_wmask(r_swmask),
        .s_icb_rsp_valid(r_srv), .s_icb_rsp_ready(r_srr), .s_icb_rsp_err(r_sre),
        .s_icb_rsp_rdata(r_srd)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_f = 1'b1; rst_r = 1'b1;
        f_mv = 2'b11; f_maddr = 64'h0; f_mread = 2'b11; f_mwdata = 64'h0; f_mwmask = 8'h0;
        f_mrr = 2'b11; f_sr = 6'h3f; f_srv = 6'h3f; f_sre = 6'h0; f_srd = {192{1'b0}};
        r_mv = 2'b00; r_maddr = 64'h0; r_mread = 2'b11; r_mwdata = 64'h0; r_mwmask = 8'h0;
        r_mrr = 2'b11; r_sr = 8'hff; r_srv = 8'h00; r_sre = 8'h00; r_srd = {256{1'b0}};
        exp_g = 2'b00;

        // Reset: everything idle even with requests and responses pending
        tick();
        chk("rst_cmd_ready", {62'h0, f_mr}, 64'h0);
        chk("rst_s_cmd_valid", {58'h0, f_sv}, 64'h0);
        chk("rst_s_rsp_ready", {58'h0, f_srr}, 64'h0);
        chk("rst_m_rsp_valid", {62'h0, f_mrv}, 64'h0);
        f_mv = 2'b00; f_srv = 6'h00;
        tick();
        rst_f = 1'b0; rst_r = 1'b0;
        tick();

        // Round-robin alternation, starting at m0
        r_mv = 2'b11; r_srv = 8'h01;
        for (int k = 0; k < 3; k++) begin
            #1;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_grant", {62'h0, r_mr}, {62'h0, exp_g});
            if (k > 0) chk("rr_rsp_route", {62'h0, r_mrv}, {62'h0, ~exp_g});
            tick();
        end
        rst_r = 1'b1;
        #1;
        chk("rr_rst_ready", {62'h0, r_mr}, 64'h0);
        chk("rr_rst_rsp", {62'h0, r_mrv}, 64'h0);
        tick();
        rst_r = 1'b0;
        #1;
        chk("rr_ptr_after_rst", {62'h0, r_mr}, 64'h1);
        r_mv = 2'b00; r_srv = 8'h00;
        tick();

        // Fixed priority: m0 then m1 to slave0, responses in order
        f_maddr = {32'h0000_0020, 32'h0000_0010}; f_mv = 2'b11;
        #1;
        chk("t1_ready_m0", {62'h0, f_mr}, 64'h1);
        chk("t1_s_valid", {58'h0, f_sv}, 64'h1);
        chk("t1_addr_m0", {32'h0, f_saddr[31:0]}, 64'h10);
        tick();
        f_mv = 2'b10;
        #1;
        chk("t1_ready_m1", {62'h0, f_mr}, 64'h2);
        chk("t1_addr_m1", {32'h0, f_saddr[31:0]}, 64'h20);
        chk("t1_no_rsp", {62'h0, f_mrv}, 64'h0);
        tick();
        f_mv = 2'b00; f_srv = 6'b000001; f_srd[31:0] = 32'hAAAA_0001;
        #1;
        chk("t1_rsp0_valid", {62'h0, f_mrv}, 64'h1);
        chk("t1_rsp0_data", f_mrd, 64'h0000_0000_AAAA_0001);
        chk("t1_rsp0_sready", {58'h0, f_srr}, 64'h1);
        tick();
        f_srd[31:0] = 32'hBBBB_0002;
        #1;
        chk("t1_rsp1_valid", {62'h0, f_mrv}, 64'h2);
        chk("t1_rsp1_data", f_mrd, 64'hBBBB_0002_0000_0000);
        tick();
        f_srv = 6'h00;
        #1;
        chk("t1_empty", {62'h0, f_mrv}, 64'h0);

        // Stall lock: m1 holds the grant while slave1 is not ready
        f_sr = 6'h00; f_maddr = {32'h2000_0004, 32'h0000_0000}; f_mv = 2'b10;
        #1;
        chk("t3_stall_ready", {62'h0, f_mr}, 64'h0);
        chk("t3_stall_sv", {58'h0, f_sv}, 64'h2);
        tick();
        f_mv = 2'b11;
        #1;
        chk("t3_lock_sv", {58'h0, f_sv}, 64'h2);
        chk("t3_lock_ready", {62'h0, f_mr}, 64'h0);
        tick();
        #1;
        chk("t3_lock_addr", {32'h0, f_saddr[63:32]}, 64'h2000_0004);
        tick();
        f_sr = 6'h3f;
        #1;
        chk("t3_m1_hs", {62'h0, f_mr}, 64'h2);
        chk("t3_m1_sv", {58'h0, f_sv}, 64'h2);
        tick();
        f_mv = 2'b01; f_srv = 6'b000010;
        #1;
        chk("t3_tgt_block", {62'h0, f_mr}, 64'h0);
        chk("t3_m1_rsp", {62'h0, f_mrv}, 64'h2);
        tick();
        f_srv = 6'h00;
        #1;
        chk("t3_m0_ready", {62'h0, f_mr}, 64'h1);
        chk("t3_m0_sv", {58'h0, f_sv}, 64'h1);
        tick();
        f_mv = 2'b00; f_srv = 6'b000001;
        #1;
        chk("t3_m0_rsp", {62'h0, f_mrv}, 64'h1);
        tick();
        f_srv = 6'h00;

        // FIFO full and target ordering
        f_maddr[31:0] = 32'h4000_0000; f_mv = 2'b01;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_fill", {62'h0, f_mr}, 64'h1);
            tick();
        end
        #1;
        chk("t4_full_ready", {62'h0, f_mr}, 64'h0);
        chk("t4_full_sv", {58'h0, f_sv}, 64'h0);
        tick();
        f_srv = 6'b000100;
        #1;
        chk("t4_pop_rsp", {62'h0, f_mrv}, 64'h1);
        chk("t4_pop_no_push", {62'h0, f_mr}, 64'h0);
        tick();
        f_srv = 6'h00;
        #1;
        chk("t4_fifth_accept", {62'h0, f_mr}, 64'h1);
        tick();
        f_maddr[31:0] = 32'h6000_0000; f_srv = 6'b000100;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t4_other_tgt_block", {62'h0, f_mr}, 64'h0);
            chk("t4_drain_rsp", {62'h0, f_mrv}, 64'h1);
            tick();
        end
        f_srv = 6'h00;
        #1;
        chk("t4_s3_ready", {62'h0, f_mr}, 64'h1);
        chk("t4_s3_sv", {58'h0, f_sv}, 64'h8);
        tick();
        f_mv = 2'b00; f_srv = 6'b001000;
        #1;
        chk("t4_s3_rsp", {62'h0, f_mrv}, 64'h1);
        tick();
        f_srv = 6'h00;

        // Unmapped address goes to the error responder
        f_maddr[31:0] = 32'hE000_0000; f_mv = 2'b01; f_srd = {192{1'b1}};
        #1;
        chk("t5_err_ready", {62'h0, f_mr}, 64'h1);
        chk("t5_err_no_sv", {58'h0, f_sv}, 64'h0);
        tick();
        f_mv = 2'b00;
        #1;
        chk("t5_err_valid", {62'h0, f_mrv}, 64'h1);
        chk("t5_err_flag", {62'h0, f_mre}, 64'h1);
        chk("t5_err_rdata", {32'h0, f_mrd[31:0]}, 64'h0);
        chk("t5_err_sready", {58'h0, f_srr}, 64'h0);
        tick();
        f_srd = {192{1'b0}};
        #1;
        chk("t5_err_popped", {62'h0, f_mrv}, 64'h0);

        // Write with withheld response, then reset mid-flight
        f_maddr[31:0] = 32'h2000_0008; f_mread = 2'b10; f_mwdata[31:0] = 32'h1234_5678;
        f_mwmask[3:0] = 4'hF; f_mv = 2'b01;
        #1;
        chk("t6_wr_ready", {62'h0, f_mr}, 64'h1);
        chk("t6_wr_sv", {58'h0, f_sv}, 64'h2);
        chk("t6_wr_data", {32'h0, f_swdata[63:32]}, 64'h1234_5678);
        chk("t6_wr_read", {58'h0, f_sread}, 64'h0);
        chk("t6_wr_mask", {60'h0, f_swmask[7:4]}, 64'hF);
        tick();
        f_mv = 2'b00;
        #1;
        chk("t6_withheld", {62'h0, f_mrv}, 64'h0);
        tick();
        f_mrr = 2'b00; f_srv = 6'b000010;
        #1;
        chk("t6_wr_rsp", {62'h0, f_mrv}, 64'h1);
        chk("t6_sready_follow", {58'h0, f_srr}, 64'h0);
        tick();
        rst_f = 1'b1;
        #1;
        chk("t6_rst_rsp", {62'h0, f_mrv}, 64'h0);
        chk("t6_rst_sready", {58'h0, f_srr}, 64'h0);
        tick();
        rst_f = 1'b0;
        #1;
        chk("t6_post_rst_rsp", {62'h0, f_mrv}, 64'h0);
        chk("t6_post_rst_sready", {58'h0, f_srr}, 64'h0);
        f_maddr[31:0] = 32'h4000_0000; f_mread = 2'b11; f_mv = 2'b01;
        #1;
        chk("t6_post_rst_accept", {62'h0, f_mr}, 64'h1);
        tick();
        f_mv = 2'b00; f_srv = 6'h00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
